distance_scheduler: RTL and testbench

- Sequencer for the squared-Euclidean distance datapath (subtract, square, accumulate) in the clustering/nearest-neighbour engine.
- On start, it streams one sample vector against each of K centroid vectors, one dimension per cycle. It reads both operands from on-chip memories and frames each vector for the datapath.
- It collects one distance result per centroid and reports the index and value of the nearest centroid.

---
 rtl/distance_scheduler.sv | 121 ++++++++++++
 tb/tb_distance_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/distance_scheduler.sv
// Sequencer for the squared-distance datapath: streams one sample against K centroids,
// one dimension per cycle, then reports the nearest centroid index and distance.
module distance_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM_WIDTH  = 8,
  parameter int K_WIDTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [DIM_WIDTH-1:0]         num_dims,
  input  logic [K_WIDTH-1:0]           num_centroids,
  output logic [DIM_WIDTH-1:0]         sample_rd_addr,
  input  logic [DATA_WIDTH-1:0]        sample_rd_data,
  output logic [K_WIDTH+DIM_WIDTH-1:0] cent_rd_addr,
  input  logic [DATA_WIDTH-1:0]        cent_rd_data,
  output logic [DATA_WIDTH-1:0]        dp_data1,
  output logic [DATA_WIDTH-1:0]        dp_data2,
  output logic                         dp_valid,
  output logic                         dp_last,
  input  logic [DATA_WIDTH-1:0]        dp_dist,
  input  logic                         dp_dist_valid,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [K_WIDTH-1:0]           best_index,
  output logic [DATA_WIDTH-1:0]        best_distance
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t               state, state_nxt;
  logic [DIM_WIDTH-1:0] dims_q, d_q, dims_last;
  logic [K_WIDTH-1:0]   cents_q, k_q, cents_last;
  logic [K_WIDTH:0]     res_cnt;
  logic                 zero_req, collecting;

  assign dims_last  = dims_q - DIM_WIDTH'(1);
  assign cents_last = cents_q - K_WIDTH'(1);
  assign zero_req   = (num_dims == '0) || (num_centroids == '0);
  assign collecting = (state == ISSUE) || (state == DRAIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !zero_req) state_nxt = ISSUE;
      ISSUE:   if ((d_q == dims_last) && (k_q == cents_last)) state_nxt = DRAIN;
      DRAIN:   if (res_cnt == {1'b0, cents_q}) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dims_q        <= '0;
      cents_q       <= '0;
      d_q           <= '0;
      k_q           <= '0;
      res_cnt       <= '0;
      error         <= 1'b0;
      dp_valid      <= 1'b0;
      dp_last       <= 1'b0;
      best_index    <= '0;
      best_distance <= '1;
    end else begin
      error    <= 1'b0;
      // Operand framing lags the address by the one-cycle memory latency.
      dp_valid <= (state == ISSUE);
      dp_last  <= (state == ISSUE) && (d_q == dims_last);
      case (state)
        IDLE: begin
          if (start) begin
            dims_q  <= num_dims;
            cents_q <= num_centroids;
            if (zero_req) begin
              error <= 1'b1;
            end else begin
              best_distance <= '1;
              best_index    <= '0;
              d_q           <= '0;
              k_q           <= '0;
              res_cnt       <= '0;
            end
          end
        end
        ISSUE: begin
          if (d_q == dims_last) begin
            d_q <= '0;
            if (k_q == cents_last) k_q <= '0;
            else                   k_q <= k_q + K_WIDTH'(1);
          end else begin
            d_q <= d_q + DIM_WIDTH'(1);
          end
        end
        default: ;
      endcase
      // Strict less-than keeps the lower index on ties.
      if (collecting && dp_dist_valid) begin
        if (dp_dist < best_distance) begin
          best_distance <= dp_dist;
          best_index    <= res_cnt[K_WIDTH-1:0];
        end
        res_cnt <= res_cnt + (K_WIDTH+1)'(1);
      end
    end
  end

  assign sample_rd_addr = d_q;
  assign cent_rd_addr   = {k_q, d_q};
  assign dp_data1       = dp_valid ? sample_rd_data : '0;
  assign dp_data2       = dp_valid ? cent_rd_data : '0;
  assign busy           = collecting;
  assign done           = (state == FINISH);

endmodule

// File: tb/tb_distance_scheduler.sv
// Directed bench for distance_scheduler with synchronous memory models and a
// squared-distance datapath model of programmable latency.
module tb_distance_scheduler;
  localparam int DW = 32, NW = 8, KW = 4;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [NW-1:0] num_dims;
  logic [KW-1:0] num_centroids;
  logic [NW-1:0] sample_rd_addr;
  logic [DW-1:0] sample_rd_data;
  logic [KW+NW-1:0] cent_rd_addr;
  logic [DW-1:0] cent_rd_data;
  logic [DW-1:0] dp_data1, dp_data2, dp_dist, best_distance;
  logic          dp_valid, dp_last, dp_dist_valid, busy, done, error;
  logic [KW-1:0] best_index;

  distance_scheduler #(.DATA_WIDTH(DW), .DIM_WIDTH(NW), .K_WIDTH(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_dims(num_dims),
    .num_centroids(num_centroids), .sample_rd_addr(sample_rd_addr),
    .sample_rd_data(sample_rd_data), .cent_rd_addr(cent_rd_addr),
    .cent_rd_data(cent_rd_data), .dp_data1(dp_data1), .dp_data2(dp_data2),
    .dp_valid(dp_valid), .dp_last(dp_last), .dp_dist(dp_dist),
    .dp_dist_valid(dp_dist_valid), .busy(busy), .done(done), .error(error),
    .best_index(best_index), .best_distance(best_distance));

  always #5 clk = ~clk;

  logic [DW-1:0] sample_mem [256];
  logic [DW-1:0] cent_mem [4096];

  always @(posedge clk) begin
    sample_rd_data <= sample_mem[sample_rd_addr];
    cent_rd_data   <= cent_mem[cent_rd_addr];
  end

  function automatic logic [31:0] sqd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    t = (a > b) ? a - b : b - a;
    return t * t;
  endfunction

  // Datapath model: accumulate until dp_last, then deliver after lat cycles.
  int          lat = 1;
  logic [31:0] acc = '0;
  logic        pv [8] = '{default: 1'b0};
  logic [31:0] pd [8] = '{default: '0};

  always @(posedge clk) begin
    pv[0] <= dp_valid && dp_last;
    pd[0] <= acc + sqd(dp_data1, dp_data2);
    if (dp_valid) acc <= dp_last ? '0 : acc + sqd(dp_data1, dp_data2);
    for (int i = 1; i < 8; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end
  assign dp_dist_valid = pv[lat-1];
  assign dp_dist       = pd[lat-1];

  // Passive monitor: counts framed operands and checks them against the memories.
  int          n_valid = 0, n_last = 0, n_done = 0, n_data_bad = 0;
  logic [11:0] prev_caddr = '0, cap_addr = '0;
  logic [7:0]  prev_saddr = '0;

  always @(negedge clk) begin
    if (dp_valid) begin
      n_valid++;
      if (dp_last) n_last++;
      cap_addr = prev_caddr;
      if (dp_data1 !== sample_mem[prev_saddr] || dp_data2 !== cent_mem[prev_caddr])
        n_data_bad++;
    end
    if (done) n_done++;
    prev_caddr = cent_rd_addr;
    prev_saddr = sample_rd_addr;
  end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [NW-1:0] nd, input logic [KW-1:0] nk);
    @(negedge clk);
    num_dims = nd;
    num_centroids = nk;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit saw_done, output bit saw_err);
    saw_done = 1'b0;
    saw_err  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done)  begin saw_done = 1'b1; break; end
      if (error) begin saw_err  = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic run_full(input logic [NW-1:0] nd, input logic [KW-1:0] nk,
                          input int budget, input string tag);
    bit sd, se;
    do_start(nd, nk);
    wait_end(budget, sd, se);
    check({tag, "_done_seen"}, 64'(sd), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({tag, "_done_width"}, 64'(done), 64'd0);
  endtask

  logic [15:0] vtr, ltr;
  logic [31:0] d1tr [16];
  logic [31:0] d2tr [16];
  int   ndone_w, overlap, nv0, nl0, nd0;
  bit   sd, se;

  initial begin
    reset = 1'b0; start = 1'b0; num_dims = '0; num_centroids = '0;
    for (int i = 0; i < 256; i++)  sample_mem[i] = '0;
    for (int i = 0; i < 4096; i++) cent_mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_dp_valid", 64'(dp_valid), 64'd0);
    check("rst_dp_data1", 64'(dp_data1), 64'd0);
    check("rst_best_index", 64'(best_index), 64'd0);
    check("rst_best_distance", 64'(best_distance), 64'hFFFF_FFFF);
    check("rst_cent_addr", 64'(cent_rd_addr), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Latency/framing: dims=3, K=2
    lat = 3;
    sample_mem[0] = 1; sample_mem[1] = 2; sample_mem[2] = 3;
    cent_mem[0] = 1; cent_mem[1] = 2; cent_mem[2] = 4;
    do_start(3, 2);
    vtr = '0; ltr = '0; ndone_w = 0; overlap = 0;
    for (int i = 0; i < 16; i++) begin
      vtr[i] = dp_valid; ltr[i] = dp_last;
      d1tr[i] = dp_data1; d2tr[i] = dp_data2;
      if (done) ndone_w++;
      if (done && busy) overlap++;
      @(negedge clk);
    end
    check("lat_valid_trace", 64'(vtr), 64'h007E);
    check("lat_last_trace", 64'(ltr), 64'h0048);
    check("lat_data1_d1", 64'(d1tr[2]), 64'd2);
    check("lat_data2_d1", 64'(d2tr[2]), 64'd2);
    check("lat_data2_d2", 64'(d2tr[3]), 64'd4);
    check("lat_data1_k1d2", 64'(d1tr[6]), 64'd3);
    check("lat_data2_k1d2", 64'(d2tr[6]), 64'd0);
    check("lat_done_count", 64'(ndone_w), 64'd1);
    check("lat_done_busy_overlap", 64'(overlap), 64'd0);
    check("lat_best_index", 64'(best_index), 64'd0);
    check("lat_best_distance", 64'(best_distance), 64'd1);

    // Ties: distances 5,5,2 then 5,5,5
    lat = 2;
    sample_mem[0] = 0; sample_mem[1] = 0;
    cent_mem[0] = 1;   cent_mem[1] = 2;
    cent_mem[256] = 2; cent_mem[257] = 1;
    cent_mem[512] = 1; cent_mem[513] = 1;
    run_full(2, 3, 100, "tie1");
    check("tie1_best_index", 64'(best_index), 64'd2);
    check("tie1_best_distance", 64'(best_distance), 64'd2);
    cent_mem[512] = 2;
    run_full(2, 3, 100, "tie2");
    check("tie2_best_index", 64'(best_index), 64'd0);
    check("tie2_best_distance", 64'(best_distance), 64'd5);

    // Zero counts
    repeat (2) @(negedge clk);
    nv0 = n_valid;
    do_start(0, 3);
    check("zd_error_pulse", 64'(error), 64'd1);
    check("zd_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("zd_error_width", 64'(error), 64'd0);
    do_start(2, 0);
    check("zk_error_pulse", 64'(error), 64'd1);
    check("zk_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("zk_error_width", 64'(error), 64'd0);
    repeat (3) @(negedge clk);
    check("zero_no_dp_valid", 64'(n_valid - nv0), 64'd0);
    check("zero_best_index", 64'(best_index), 64'd0);
    check("zero_best_distance", 64'(best_distance), 64'd5);

    // Start while busy is ignored
    lat = 1;
    sample_mem[0] = 10; sample_mem[1] = 20; sample_mem[2] = 30; sample_mem[3] = 40;
    for (int d = 0; d < 4; d++) cent_mem[d] = 0;
    cent_mem[256] = 11; cent_mem[257] = 20; cent_mem[258] = 30; cent_mem[259] = 40;
    cent_mem[512] = 10; cent_mem[513] = 20; cent_mem[514] = 30; cent_mem[515] = 42;
    nv0 = n_valid; nl0 = n_last;
    do_start(4, 3);
    repeat (3) @(negedge clk);
    num_dims = 2; num_centroids = 5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(200, sd, se);
    check("swb_done_seen", 64'(sd), 64'd1);
    repeat (3) @(negedge clk);
    check("swb_valid_count", 64'(n_valid - nv0), 64'd12);
    check("swb_last_count", 64'(n_last - nl0), 64'd3);
    check("swb_final_addr", 64'(cap_addr), 64'd515);
    check("swb_best_index", 64'(best_index), 64'd1);
    check("swb_best_distance", 64'(best_distance), 64'd1);
    check("swb_data_ok", 64'(n_data_bad), 64'd0);

    // Reset in DRAIN with one result outstanding
    lat = 6;
    sample_mem[0] = 3; sample_mem[1] = 3;
    cent_mem[0] = 0; cent_mem[1] = 0;
    cent_mem[256] = 3; cent_mem[257] = 4;
    nd0 = n_done;
    do_start(2, 2);
    repeat (9) @(negedge clk);
    check("mr_busy_before", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_dp_valid", 64'(dp_valid), 64'd0);
    check("mr_best_index", 64'(best_index), 64'd0);
    check("mr_best_distance", 64'(best_distance), 64'hFFFF_FFFF);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mr_no_done", 64'(n_done - nd0), 64'd0);
    check("mr_stale_ignored", 64'(best_distance), 64'hFFFF_FFFF);
    check("mr_idle_busy", 64'(busy), 64'd0);
    lat = 2;
    run_full(2, 2, 100, "mr_rerun");
    check("mr_rerun_best_index", 64'(best_index), 64'd1);
    check("mr_rerun_best_distance", 64'(best_distance), 64'd1);

    // Max size: 255 dims x 15 centroids, nearest at k=14
    lat = 4;
    for (int d = 0; d < 255; d++) sample_mem[d] = 32'(d + 100);
    for (int k = 0; k < 15; k++)
      for (int d = 0; d < 255; d++) cent_mem[k*256 + d] = 32'(d + 100 + (15 - k));
    nv0 = n_valid; nl0 = n_last; n_data_bad = 0;
    run_full(255, 15, 5000, "max");
    repeat (2) @(negedge clk);
    check("max_valid_count", 64'(n_valid - nv0), 64'd3825);
    check("max_last_count", 64'(n_last - nl0), 64'd15);
    check("max_final_addr", 64'(cap_addr), 64'd3838);
    check("max_best_index", 64'(best_index), 64'd14);
    check("max_best_distance", 64'(best_distance), 64'd255);
    check("max_data_ok", 64'(n_data_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
